// File: rtl/lpf_axis_pkg.sv
// Shared defaults, FSM states and lane widening helper for the filter-output AXI4-Stream framer.
// Pure declarations; no timing or flow-control behaviour lives here.
package lpf_axis_pkg;

  localparam int NSAMP_DEF    = 8;
  localparam int IN_BITS_DEF  = 12;
  localparam int OUT_BITS_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Widens the low in_bits of sample to 32 bits; the caller truncates to its lane width.
  function automatic logic [31:0] lane_extend(input logic [31:0] sample,
                                              input int          in_bits,
                                              input logic        sign_ext);
    logic [31:0] r;
    logic        msb;
    msb = sign_ext & sample[5'(in_bits - 1)];
    for (int b = 0; b < 32; b++) begin
      r[b] = (b < in_bits) ? sample[b] : msb;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// Synchronous beat FIFO, write-to-valid latency 1 cycle, full-rate push+pop.
// Backpressure: wr_rdy_o reflects fullness after this cycle's pop; rd_vld_o never depends on rd_rdy_i.
module axis_beat_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             wr_rdy_o,
  output logic             rd_vld_o,
  output logic [WIDTH-1:0] rd_dat_o,
  input  logic             rd_rdy_i
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  assign rd_vld_o = (cnt_q != '0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign pop      = rd_vld_o && rd_rdy_i;
  // A slot freed by this cycle's pop can be refilled in the same cycle.
  assign wr_rdy_o = (cnt_q != CNT_FULL) || pop;
  assign push     = wr_vld_i && wr_rdy_o;
  assign cnt_d    = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lpf_axis_framer.sv
// Repacks filter beats to 16-bit lanes and frames them onto AXI4-Stream; 1 cycle input-to-tvalid.
// Never stalls upstream: beats arriving with the FIFO full are dropped and counted.
module lpf_axis_framer
  import lpf_axis_pkg::*;
#(
  parameter int NSAMP      = NSAMP_DEF,
  parameter int IN_BITS    = IN_BITS_DEF,
  parameter int OUT_BITS   = OUT_BITS_DEF,
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int SIGN_EXT   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NSAMP*IN_BITS-1:0]  in_i,
  input  logic                      in_valid_i,
  input  logic                      start_i,
  input  logic                      continuous_i,
  input  logic                      clear_i,
  output logic [NSAMP*OUT_BITS-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      busy_o,
  output logic                      overflow_o,
  output logic [15:0]               drop_count_o,
  output logic [15:0]               frame_count_o
);

  localparam int            OUT_W     = NSAMP * OUT_BITS;
  localparam int            CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  logic [OUT_W-1:0] lanes_w;
  state_e           state_q, state_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_count_q, drop_count_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             fifo_wr_vld, fifo_wr_rdy, fifo_rd_vld;
  logic [OUT_W:0]   fifo_rd_dat;
  logic             accept, drop, tlast_hs;

  for (genvar k = 0; k < NSAMP; k++) begin : g_lane
    logic [OUT_BITS-1:0] ext_w;
    assign ext_w = OUT_BITS'(lane_extend(32'(in_i[IN_BITS*k +: IN_BITS]), IN_BITS, SIGN_EXT != 0));
    assign lanes_w[OUT_BITS*k +: OUT_BITS] = ext_w;
  end

  assign fifo_wr_vld = (state_q == ST_RUN) && in_valid_i;
  assign accept      = fifo_wr_vld && fifo_wr_rdy;
  assign drop        = fifo_wr_vld && !fifo_wr_rdy;
  assign tlast_hs    = fifo_rd_vld && m_axis_tready && fifo_rd_dat[OUT_W];

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_RUN;
          beat_cnt_d = '0;
        end
      end
      ST_RUN: begin
        // Only accepted beats advance the count, so frames stay exactly FRAME_LEN long.
        if (accept) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            if (!continuous_i) begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d    = overflow_q;
    drop_count_d  = drop_count_q;
    frame_count_d = frame_count_q;
    if (clear_i) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
    if (tlast_hs) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  axis_beat_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_vld_i (fifo_wr_vld),
    .wr_dat_i ({(beat_cnt_q == LAST_BEAT), lanes_w}),
    .wr_rdy_o (fifo_wr_rdy),
    .rd_vld_o (fifo_rd_vld),
    .rd_dat_o (fifo_rd_dat),
    .rd_rdy_i (m_axis_tready)
  );

  assign m_axis_tvalid = fifo_rd_vld;
  assign m_axis_tdata  = fifo_rd_dat[OUT_W-1:0];
  assign m_axis_tlast  = fifo_rd_dat[OUT_W];
  assign busy_o        = (state_q == ST_RUN);
  assign overflow_o    = overflow_q;
  assign drop_count_o  = drop_count_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_lpf_axis_framer.sv
// Scoreboard bench for lpf_axis_framer: sign- and zero-extending instances share one stimulus stream.
module tb_lpf_axis_framer;

  localparam int FL    = 64;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [95:0]  in_dat;
  logic         in_vld, start, cont, clr, tready;

  logic [127:0] dat1, dat0;
  logic         vld1, vld0, last1, last0, busy1, busy0, ovf1, ovf0;
  logic [15:0]  drop1, drop0, fc1, fc0;

  always #5 clk = ~clk;

  lpf_axis_framer #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .SIGN_EXT(1)) dut_sx (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_dat), .in_valid_i(in_vld), .start_i(start),
    .continuous_i(cont), .clear_i(clr), .m_axis_tdata(dat1), .m_axis_tvalid(vld1),
    .m_axis_tready(tready), .m_axis_tlast(last1), .busy_o(busy1), .overflow_o(ovf1),
    .drop_count_o(drop1), .frame_count_o(fc1));

  lpf_axis_framer #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .SIGN_EXT(0)) dut_zx (
    .clk_i(clk), .rst_ni(rst_n), .in_i(in_dat), .in_valid_i(in_vld), .start_i(start),
    .continuous_i(cont), .clear_i(clr), .m_axis_tdata(dat0), .m_axis_tvalid(vld0),
    .m_axis_tready(tready), .m_axis_tlast(last0), .busy_o(busy0), .overflow_o(ovf0),
    .drop_count_o(drop0), .frame_count_o(fc0));

  typedef struct {
    logic [127:0] d1;
    logic [127:0] d0;
    logic         last;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [127:0] hs_d1[$];
  logic [127:0] hs_d0[$];
  logic         hs_last[$];

  int tests = 0;
  int fails = 0;

  int m_occ, m_cnt, m_drops, occ_after;
  bit m_run, m_ovf;

  logic         prev_stall;
  logic [127:0] prev_dat;
  logic         prev_last;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] ext(input logic [95:0] x, input bit sx);
    logic [127:0] r;
    logic [11:0]  s;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      s = x[12*k +: 12];
      r[16*k +: 16] = sx ? {{4{s[11]}}, s} : {4'h0, s};
    end
    return r;
  endfunction

  function automatic logic [95:0] gen(input int mode, input int c);
    logic [95:0] x;
    x = '0;
    for (int k = 0; k < 8; k++) begin
      if (mode == 0) x[12*k +: 12] = 12'(k * 100);
      else if (mode == 1) x[12*k +: 12] = 12'(c * 8 + k);
      else if (c == 0 && k == 0) x[11:0] = 12'hC18;
    end
    return x;
  endfunction

  function automatic int count_last();
    int n = 0;
    foreach (hs_last[i]) if (hs_last[i]) n++;
    return n;
  endfunction

  // Reference model: advances on each active edge using the inputs presented before it.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_occ = 0; m_run = 0; m_cnt = 0; m_drops = 0; m_ovf = 0;
      sb.delete();
    end else begin
      occ_after = m_occ - (((m_occ > 0) && tready) ? 1 : 0);
      if (m_run && in_vld) begin
        if (occ_after < DEPTH) begin
          sb.push_back(exp_t'{ext(in_dat, 1'b1), ext(in_dat, 1'b0), (m_cnt == FL - 1)});
          occ_after++;
          if (m_cnt == FL - 1) begin
            m_cnt = 0;
            if (!cont) m_run = 0;
          end else begin
            m_cnt++;
          end
        end else if (!clr) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end else if (!m_run && start) begin
        m_run = 1;
        m_cnt = 0;
      end
      if (clr) begin
        m_drops = 0;
        m_ovf   = 0;
      end
      m_occ = occ_after;
    end
  end

  // Monitor: values seen at the falling edge are what the next rising edge will sample.
  initial begin
    prev_stall = 1'b0;
    prev_dat   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("tvalid_sx", 128'(vld1), 128'(m_occ != 0));
        chk("tvalid_zx", 128'(vld0), 128'(m_occ != 0));
        chk("drop_count", 128'(drop1), 128'(m_drops[15:0]));
        chk("overflow", 128'(ovf1), 128'(m_ovf));
        if (prev_stall) begin
          chk("stall_hold_valid", 128'(vld1), 128'(1));
          chk("stall_hold_data", dat1, prev_dat);
          chk("stall_hold_last", 128'(last1), 128'(prev_last));
        end
        if (vld1 && tready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got tdata %0h, expected no beat", dat1);
          end else begin
            e = sb.pop_front();
            chk("tdata_sx", dat1, e.d1);
            chk("tdata_zx", dat0, e.d0);
            chk("tlast", 128'(last1), 128'(e.last));
          end
          hs_d1.push_back(dat1);
          hs_d0.push_back(dat0);
          hs_last.push_back(last1);
        end
        prev_stall = vld1 && !tready;
        prev_dat   = dat1;
        prev_last  = last1;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    hs_d1.delete();
    hs_d0.delete();
    hs_last.delete();
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input int mode, input int st_at, input int st_len,
                        input int gp_at, input int gp_len, input int clr_at);
    for (int c = 0; c < n; c++) begin
      tready = !(c >= st_at && c < st_at + st_len);
      in_vld = !(c >= gp_at && c < gp_at + gp_len);
      clr    = (c == clr_at);
      in_dat = gen(mode, c);
      tick();
    end
    in_vld = 1'b0;
    clr    = 1'b0;
    tready = 1'b1;
    in_dat = '0;
  endtask

  task automatic drain();
    int i = 0;
    while ((sb.size() != 0 || vld1) && i < 100) begin
      tick();
      i++;
    end
    chk("drain_done", 128'(vld1 || (sb.size() != 0)), 128'(0));
  endtask

  task automatic chk_frame(input string name);
    chk({name, "_beats"}, 128'(hs_last.size()), 128'(FL));
    chk({name, "_tlast_cnt"}, 128'(count_last()), 128'(1));
    if (hs_last.size() == FL) chk({name, "_tlast_pos"}, 128'(hs_last[FL-1]), 128'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_dat = '0; in_vld = 1'b0; start = 1'b0; cont = 1'b0; clr = 1'b0; tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", 128'(vld1), 128'(0));
    chk("rst_tlast", 128'(last1), 128'(0));
    chk("rst_tdata", dat1, 128'(0));
    chk("rst_busy", 128'(busy1), 128'(0));
    chk("rst_overflow", 128'(ovf1), 128'(0));
    chk("rst_drop", 128'(drop1), 128'(0));
    chk("rst_frames", 128'(fc1), 128'(0));
    rst_n = 1'b1;
    tick();

    // Basic frame, lane k = k*100
    clr_logs();
    start_frame();
    stream(FL, 0, -1, 0, -1, 0, -1);
    drain();
    chk_frame("basic");
    if (hs_d1.size() == FL) begin
      chk("basic_lane3", 128'(hs_d1[0][63:48]), 128'(16'h012C));
      chk("basic_lane7", 128'(hs_d1[FL-1][127:112]), 128'(16'h02BC));
    end
    chk("basic_frames", 128'(fc1), 128'(1));
    chk("basic_busy_fall", 128'(busy1), 128'(0));

    // Sign extension of -1000 on lane 0
    clr_logs();
    start_frame();
    stream(FL, 2, -1, 0, -1, 0, -1);
    drain();
    if (hs_d1.size() > 0) begin
      chk("sext_lane0", 128'(hs_d1[0][15:0]), 128'(16'hFC18));
      chk("zext_lane0", 128'(hs_d0[0][15:0]), 128'(16'h0C18));
    end
    chk("sext_frames", 128'(fc1), 128'(2));

    // Back-pressure for 3 cycles: absorbed without loss
    clr_logs();
    start_frame();
    stream(FL, 1, 20, 3, -1, 0, -1);
    drain();
    chk_frame("bp");
    chk("bp_drops", 128'(drop1), 128'(0));
    chk("bp_overflow", 128'(ovf1), 128'(0));
    if (hs_d1.size() == FL) begin
      chk("bp_order21", 128'(hs_d1[21][15:0]), 128'(16'h00A8));
      chk("bp_order63", 128'(hs_d1[63][15:0]), 128'(16'h01F8));
    end

    // Overflow: drain FIFO, then 10 stalled cycles: 4 stored, 6 dropped
    clr_logs();
    start_frame();
    stream(80, 1, 12, 10, 10, 2, -1);
    drain();
    chk_frame("ovf");
    chk("ovf_drops", 128'(drop1), 128'(6));
    chk("ovf_flag", 128'(ovf1), 128'(1));
    if (hs_d1.size() == FL) chk("ovf_resume_beat", 128'(hs_d1[14][15:0]), 128'(16'h00B0));
    chk("ovf_frames", 128'(fc1), 128'(4));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_drops", 128'(drop1), 128'(0));
    chk("clear_flag", 128'(ovf1), 128'(0));

    // Clear coinciding with a drop: clear wins
    clr_logs();
    start_frame();
    stream(70, 1, 0, 6, -1, 0, 5);
    drain();
    chk_frame("clrdrop");
    chk("clrdrop_drops", 128'(drop1), 128'(0));
    chk("clrdrop_flag", 128'(ovf1), 128'(0));
    chk("clrdrop_frames", 128'(fc1), 128'(5));

    // Continuous mode, 200 cycles
    clr_logs();
    cont = 1'b1;
    start_frame();
    stream(200, 1, -1, 0, -1, 0, -1);
    repeat (2) tick();
    chk("cont_beats", 128'(hs_last.size()), 128'(200));
    chk("cont_tlast_cnt", 128'(count_last()), 128'(3));
    if (hs_last.size() == 200) begin
      chk("cont_tlast64", 128'(hs_last[63]), 128'(1));
      chk("cont_tlast128", 128'(hs_last[127]), 128'(1));
      chk("cont_tlast192", 128'(hs_last[191]), 128'(1));
    end
    chk("cont_frames", 128'(fc1), 128'(8));
    chk("cont_busy", 128'(busy1), 128'(1));

    // Reset mid-frame after beat 20
    cont = 1'b0;
    stream(12, 1, -1, 0, -1, 0, -1);
    chk("prerst_tvalid", 128'(vld1), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tvalid", 128'(vld1), 128'(0));
    chk("rst_async_busy", 128'(busy1), 128'(0));
    chk("rst_async_frames", 128'(fc1), 128'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clr_logs();
    chk("postrst_idle", 128'(busy1), 128'(0));
    stream(5, 1, -1, 0, -1, 0, -1);
    tick();
    chk("postrst_ignored", 128'(hs_last.size()), 128'(0));
    start_frame();
    stream(FL, 0, -1, 0, -1, 0, -1);
    drain();
    chk_frame("postrst");
    chk("postrst_frames", 128'(fc1), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lpf_axis_framer.md
Name: lpf_axis_framer

Overview:
Sits directly downstream of shannon_whitaker_lpfull_v2. It takes the filter's 8-sample-per-clock output (8 x 12-bit, packed 96-bit) and repacks each lane to 16 bits. It then emits fixed-length frames on a 128-bit AXI4-Stream master with tlast, for DMA or capture logic. A small FIFO absorbs downstream back-pressure, and overflow is reported, never stalled upstream.

Parameters:
NSAMP, 8, samples per clock (lanes)
IN_BITS, 12, bits per input sample
OUT_BITS, 16, bits per output lane
FRAME_LEN, 64, accepted beats per frame (>=2)
FIFO_DEPTH, 4, beat FIFO entries (power of 2, >=2)
SIGN_EXT, 1, 1 = sign-extend lanes, 0 = zero-extend

Ports:
clk_i  in  1  single clock domain (filter clock)
rst_ni  in  1  asynchronous, active-low reset
in_i  in  NSAMP*IN_BITS  filter output, sample k at bits [IN_BITS*k +: IN_BITS]
in_valid_i  in  1  in_i holds a new beat this cycle
start_i  in  1  one-cycle pulse; arms one frame (ignored unless IDLE)
continuous_i  in  1  1 = re-arm automatically after each frame
clear_i  in  1  clears overflow_o and drop_count_o
m_axis_tdata  out  NSAMP*OUT_BITS  lane k at bits [OUT_BITS*k +: OUT_BITS]
m_axis_tvalid  out  1  AXI4S valid
m_axis_tready  in  1  AXI4S ready
m_axis_tlast  out  1  last beat of frame
busy_o  out  1  state == RUN
overflow_o  out  1  sticky: at least one beat dropped
drop_count_o  out  16  dropped beats, saturating at 0xFFFF
frame_count_o  out  16  completed frames (tlast handshakes), wraps

Behaviour:
- Reset (asynchronous assert, rst_ni low): state IDLE, FIFO empty.
- All outputs read 0 in reset: m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy_o, overflow_o, drop_count_o, frame_count_o.
- Reset mid-frame discards the partial frame. No tlast is emitted for it.
- Lane repack: out lane k = {ext, in lane k}. ext is (OUT_BITS-IN_BITS) copies of the lane MSB if SIGN_EXT, else zeros. Data is LSB-aligned.
- FSM IDLE:
  - start_i=1 moves to RUN next edge and clears the beat counter.
  - in_valid_i beats are ignored and not counted as drops.
- FSM RUN, beat acceptance:
  - A beat is accepted when in_valid_i=1 and the FIFO is not full at the clock edge.
  - Accepted beats are written with tlast = (beat_cnt == FRAME_LEN-1), and beat_cnt increments.
- FSM RUN, dropped beats:
  - in_valid_i=1 with the FIFO full drops the beat.
  - A drop sets overflow_o, increments drop_count_o (saturating) and does not advance beat_cnt. Frames therefore always contain exactly FRAME_LEN beats.
- FSM RUN, frame end:
  - After writing the tlast beat: continuous_i=1 stays in RUN with beat_cnt=0; otherwise go to IDLE.
  - start_i in RUN is ignored.
- FIFO:
  - Registered output; write-to-tvalid latency is 1 cycle. An accepted beat at edge N gives tvalid high after edge N.
  - Pop on tvalid & tready.
  - Simultaneous push and pop when full: push is accepted, since full is evaluated after the pop. No bubble is allowed at full rate with tready=1.
  - tdata and tlast are held stable while tvalid=1 and tready=0 (AXI4S rule).
  - tvalid never depends combinationally on tready.
- frame_count_o increments on each handshake with tlast=1.
- clear_i:
  - Zeroes overflow_o and drop_count_o next edge.
  - clear_i together with a drop in the same cycle: clear wins, and the counter reads 0.
- Throughput: one beat per clock sustained when m_axis_tready=1.

Decomposition:
- Package lpf_axis_pkg:
  - NSAMP, IN_BITS, OUT_BITS defaults.
  - State enum {IDLE, RUN}.
  - Function lane_extend(sample, sign_ext).
- One natural sub-module: axis_beat_fifo. It is a synchronous FIFO with registered output and a WIDTH=NSAMP*OUT_BITS+1 payload (data + tlast), and is reusable by other capture paths.

Test Plan:
- Basic frame:
  - Stimulus: reset, tready=1, FRAME_LEN=64, start_i pulse, then 64 beats with lane k = k*100.
  - Required: 64 handshakes; lane k reads 0x0000+k*100 (lane 3 = 0x012C); tlast only on beat 64; frame_count_o=1; busy_o falls.
- Sign extension:
  - Stimulus: impulse of 12'hC18 (-1000) on lane 0.
  - Required: tdata[15:0]=16'hFC18 with SIGN_EXT=1; 16'h0C18 with SIGN_EXT=0.
- Back-pressure without loss:
  - Stimulus: tready held low 3 cycles mid-frame with FIFO_DEPTH=4, in_valid_i every cycle.
  - Required: no drops, overflow_o=0, data order preserved, tdata stable while stalled.
- Overflow:
  - Stimulus: tready low 10 cycles with in_valid_i continuous.
  - Required: overflow_o=1; drop_count_o=6 (4 stored, then 6 dropped); the frame still totals 64 beats with tlast on the 64th accepted.
  - Follow-up: clear_i returns overflow_o and drop_count_o to 0.
- Continuous mode:
  - Stimulus: continuous_i=1, one start_i, 200 cycles, tready=1.
  - Required: 3 tlasts at handshakes 64, 128, 192; frame_count_o=3; busy_o remains 1.
- Reset mid-frame:
  - Stimulus: rst_ni low after beat 20.
  - Required: tvalid=0 immediately (async); after release the FSM is IDLE and the next start_i yields a full 64-beat frame with no residual data.
